pipe_skid_slice: RTL

PIPE_SKID_SLICE -- requirements
Module: pipe_skid_slice

---
 rtl/pipe_skid_slice_pkg.sv | 12 +
 rtl/pipe_skid_slice_dffs_en.sv | 19 +
 rtl/pipe_skid_slice.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipe_skid_slice_pkg.sv
// Shared types and constants for the pipe_skid_slice two-entry skid buffer.
package pipe_skid_slice_pkg;

    localparam int SKID_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_slice_dffs_en.sv
// dffs_en: WIDTH-bit enable flop with synchronous active-low reset to zero.
module dffs_en #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_l)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipe_skid_slice.sv
// Two-entry valid/ready skid slice: main register drives the output, skid absorbs one beat.
// Optional stall counter enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_slice
    import pipe_skid_slice_pkg::*;
#(
    parameter int WIDTH = SKID_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_SKID_PERF_EN
    output logic [31:0]      stall_cnt,
`endif
    output logic [WIDTH-1:0] out_data
);

    skid_state_e       state;
    logic              in_fire;
    logic              out_fire;
    logic              main_en;
    logic              skid_en;
    logic [WIDTH-1:0]  main_d;
    logic [WIDTH-1:0]  skid_q;

    // Handshake flags depend only on the state register, so no comb path in->out.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        if (!flush) begin
            unique case (state)
                EMPTY: main_en = in_fire;
                BUSY: begin
                    main_en = in_fire & out_fire;
                    skid_en = in_fire & ~out_fire;
                end
                FULL: begin
                    main_en = out_fire;
                    main_d  = skid_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (in_fire) state <= BUSY;
                BUSY: begin
                    if (in_fire && !out_fire)
                        state <= FULL;
                    else if (!in_fire && out_fire)
                        state <= EMPTY;
                end
                FULL:    if (out_fire) state <= BUSY;
                default: state <= EMPTY;
            endcase
        end
    end

    dffs_en #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .rst_l (rst_l),
        .en    (main_en),
        .d     (main_d),
        .q     (out_data)
    );

    dffs_en #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst_l (rst_l),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

`ifdef PIPE_SKID_PERF_EN
    // Counts downstream back-pressure cycles; survives flush, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_l)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule
